// File: rtl/config_loader.sv
// Serialises host words onto the fabric configuration chain with a registered, glitch-free config_clk.
// Build option: define CONFIG_LOADER_READBACK_EN to add the readback parity verify pass.
module config_loader #(
    parameter int CHAIN_LENGTH = 65,
    parameter int WORD_WIDTH   = 8,
    parameter int CNT_WIDTH    = $clog2(CHAIN_LENGTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  config_out,
    output logic                  config_en,
    output logic                  config_clk,
    input  logic                  readback_in,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            dbg_state
);

    localparam int IDX_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(CHAIN_LENGTH);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_SHIFT_LO  = 3'd2,
        S_SHIFT_HI  = 3'd3
`ifdef CONFIG_LOADER_READBACK_EN
        ,
        S_VERIFY_LO = 3'd4,
        S_VERIFY_HI = 3'd5
`endif
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WORD_WIDTH-1:0] r_buf;
    logic [WORD_WIDTH-1:0] w_buf_shr;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;
    logic                  w_last_shift;
    logic                  w_accept;
    logic                  w_lo_bit;
    logic                  w_clk_nxt;
    logic                  w_done_evt;
    logic                  r_s_ready;
    logic                  r_config_out;
    logic                  r_config_en;
    logic                  r_config_clk;
    logic                  r_busy;
    logic                  r_done;

    // Host stream: a word transfers on a rising clk edge where s_valid and s_ready
    // are both high; s_ready is high only while waiting in FETCH and s_data must be
    // held stable by the host until that transfer edge.
    assign w_accept     = (r_state == S_FETCH) && s_valid && r_s_ready;
    assign w_cnt_inc    = r_cnt + CNT_WIDTH'(1);
    assign w_last_shift = (w_cnt_inc == LAST_CNT);
    assign w_buf_shr    = r_buf >> 1;
    assign w_lo_bit     = (r_state == S_FETCH) ? s_data[0] : w_buf_shr[0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (start) w_state_nxt = S_FETCH;
            S_FETCH:    if (w_accept) w_state_nxt = S_SHIFT_LO;
            S_SHIFT_LO: w_state_nxt = S_SHIFT_HI;
            S_SHIFT_HI: begin
                if (w_last_shift)
`ifdef CONFIG_LOADER_READBACK_EN
                    w_state_nxt = S_VERIFY_LO;
`else
                    w_state_nxt = S_IDLE;
`endif
                else if (r_bit_idx == LAST_IDX)
                    w_state_nxt = S_FETCH;
                else
                    w_state_nxt = S_SHIFT_LO;
            end
`ifdef CONFIG_LOADER_READBACK_EN
            S_VERIFY_LO: w_state_nxt = S_VERIFY_HI;
            S_VERIFY_HI: w_state_nxt = w_last_shift ? S_IDLE : S_VERIFY_LO;
`endif
            default:    w_state_nxt = S_IDLE;
        endcase
    end

`ifdef CONFIG_LOADER_READBACK_EN
    assign w_clk_nxt  = (w_state_nxt == S_SHIFT_HI) || (w_state_nxt == S_VERIFY_HI);
    assign w_done_evt = (r_state == S_VERIFY_HI) && w_last_shift;
`else
    assign w_clk_nxt  = (w_state_nxt == S_SHIFT_HI);
    assign w_done_evt = (r_state == S_SHIFT_HI) && w_last_shift;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_buf        <= '0;
            r_bit_idx    <= '0;
            r_cnt        <= '0;
            r_s_ready    <= 1'b0;
            r_config_out <= 1'b0;
            r_config_en  <= 1'b0;
            r_config_clk <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_s_ready    <= (w_state_nxt == S_FETCH);
            r_config_en  <= (w_state_nxt != S_IDLE);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_config_clk <= w_clk_nxt;
            if ((r_state == S_IDLE) && start) begin
                r_done <= 1'b0;
                r_cnt  <= '0;
            end
            if (w_accept) begin
                r_buf     <= s_data;
                r_bit_idx <= '0;
            end
            // Buffer advances every shift; a stale tail is overwritten at the next accept.
            if (r_state == S_SHIFT_HI) begin
                r_cnt     <= w_cnt_inc;
                r_buf     <= w_buf_shr;
                r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
            if (w_state_nxt == S_SHIFT_LO) r_config_out <= w_lo_bit;
            if (w_done_evt) r_done <= 1'b1;
`ifdef CONFIG_LOADER_READBACK_EN
            if ((r_state == S_SHIFT_HI) && w_last_shift) r_cnt <= '0;
            if (r_state == S_VERIFY_HI) r_cnt <= w_cnt_inc;
            if (w_state_nxt == S_VERIFY_LO) r_config_out <= readback_in;
`endif
        end
    end

`ifdef CONFIG_LOADER_READBACK_EN
    logic r_par_tx;
    logic r_par_rx;
    logic r_error;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par_tx <= 1'b0;
            r_par_rx <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && start) begin
                r_par_tx <= 1'b0;
                r_par_rx <= 1'b0;
                r_error  <= 1'b0;
            end
            if (r_state == S_SHIFT_HI) r_par_tx <= r_par_tx ^ r_buf[0];
            if (w_state_nxt == S_VERIFY_LO) r_par_rx <= r_par_rx ^ readback_in;
            if (w_done_evt) r_error <= r_par_tx ^ r_par_rx;
        end
    end

    assign error = r_error;
`else
    logic w_unused;
    assign w_unused = ^{readback_in, r_buf[0]};
    assign error    = 1'b0;
`endif

    assign s_ready    = r_s_ready;
    assign config_out = r_config_out;
    assign config_en  = r_config_en;
    assign config_clk = r_config_clk;
    assign busy       = r_busy;
    assign done       = r_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader: 65-bit chain model, host stream driver, cycle/edge monitors.
module tb_config_loader;

    localparam int CL = 65;
    localparam int WW = 8;
    localparam int NW = (CL + WW - 1) / WW;
`ifdef CONFIG_LOADER_READBACK_EN
    localparam int EXP_EDGES      = 2 * CL;
    localparam int EXP_DONE       = 270;
    localparam int EXP_STALL_DONE = 280;
    localparam int EXP_FLIP_ERR   = 1;
`else
    localparam int EXP_EDGES      = CL;
    localparam int EXP_DONE       = 140;
    localparam int EXP_STALL_DONE = 150;
    localparam int EXP_FLIP_ERR   = 0;
`endif

    // clock / reset / DUT
    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [WW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          config_out;
    logic          config_en;
    logic          config_clk;
    logic          readback_in;
    logic          busy;
    logic          done;
    logic          error;
    logic [2:0]    dbg_state;

    always #5 clk = ~clk;

    config_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .config_out  (config_out),
        .config_en   (config_en),
        .config_clk  (config_clk),
        .readback_in (readback_in),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .dbg_state   (dbg_state)
    );

    // chain model: index 0 is the head, index CL-1 the far end feeding readback
    logic [CL-1:0] chain = '0;
    int            edge_cnt = 0;
    int            flip_edge = -1;

    assign readback_in = chain[CL-1];

    always @(posedge config_clk) begin
        chain = {chain[CL-2:0], config_out};
        edge_cnt = edge_cnt + 1;
        if (edge_cnt == flip_edge) chain[10] = ~chain[10];
    end

    // scoreboard
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [WW-1:0] tx_words [NW];

    // bit k of the stream is word k/WW bit k%WW; it ends at chain position CL-1-k
    function automatic logic [CL-1:0] model_chain();
        logic [CL-1:0] m;
        m = '0;
        for (int k = 0; k < CL; k++) m[CL-1-k] = tx_words[k / WW][k % WW];
        return m;
    endfunction

    // driver
    logic abort_load;
    logic stall_active;
    int   res_done_cyc, res_first_clk, res_stall_hi, res_edges;
    logic res_rdy1, res_done1, res_poke_hi;

    task automatic run_load(input int stall_word, input int stall_cyc, input int rst_edge,
                            input int poke_edge);
        int base;
        abort_load   = 1'b0;
        stall_active = 1'b0;
        res_poke_hi  = 1'b0;
        base = edge_cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        fork
            begin : host
                for (int w = 0; w < NW && !abort_load; w++) begin
                    int guard;
                    guard = 0;
                    @(negedge clk);
                    if (w == stall_word) begin
                        s_valid = 1'b0;
                        while (!s_ready && !abort_load && guard < 500) begin
                            @(negedge clk);
                            guard++;
                        end
                        stall_active = 1'b1;
                        repeat (stall_cyc) @(negedge clk);
                        stall_active = 1'b0;
                    end
                    s_data  = tx_words[w];
                    s_valid = 1'b1;
                    while (!s_ready && !abort_load && guard < 1000) begin
                        @(negedge clk);
                        guard++;
                    end
                    if (!abort_load) @(posedge clk);
                end
                @(negedge clk);
                s_valid = 1'b0;
            end
            begin : watch
                int cyc;
                cyc = 0;
                res_first_clk = 0;
                res_stall_hi  = 0;
                while (!abort_load && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                    if (cyc == 1) begin
                        res_rdy1  = s_ready;
                        res_done1 = done;
                    end
                    if (config_clk && res_first_clk == 0) res_first_clk = cyc;
                    if (stall_active && config_clk) res_stall_hi++;
                    if (done) break;
                end
                res_done_cyc = cyc;
            end
            begin : ctl
                int guard;
                int target;
                guard  = 0;
                target = (rst_edge > 0) ? rst_edge : poke_edge;
                if (target > 0) begin
                    while (edge_cnt - base < target && guard < 2000) begin
                        @(negedge clk);
                        guard++;
                    end
                    if (rst_edge > 0) begin
                        rst = 1'b1;
                        abort_load = 1'b1;
                        #1;
                        check("rst_mid_outputs_zero",
                              {s_ready, config_out, config_en, config_clk, busy, done, error}, 7'b0);
                        check("rst_mid_state_idle", dbg_state, 3'd0);
                        repeat (2) @(negedge clk);
                        rst = 1'b0;
                    end else begin
                        res_poke_hi = config_clk;
                        start = 1'b1;
                        @(posedge clk);
                        #1 start = 1'b0;
                    end
                end
            end
        join
        res_edges = edge_cnt - base;
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    logic [CL-1:0] ref_chain;

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {s_ready, config_out, config_en, config_clk, busy, done, error, dbg_state}, 10'b0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_outputs",
              {s_ready, config_out, config_en, config_clk, busy, done, error, dbg_state}, 10'b0);

        // full load of ones
        for (int w = 0; w < NW; w++) tx_words[w] = 8'hFF;
        run_load(-1, 0, 0, 0);
        check("ones_edges", res_edges, EXP_EDGES);
        check("ones_chain", chain, {CL{1'b1}});
        check("ones_done_cycle", res_done_cyc, EXP_DONE);
        check("ones_first_clk_cycle", res_first_clk, 3);
        check("ones_fetch_ready_c1", res_rdy1, 1'b1);
        check("ones_end_flags", {busy, done, config_en, config_clk, s_ready, error}, 6'b010000);

        // stalled mixed-pattern load
        tx_words[0] = 8'hA5; tx_words[1] = 8'h3C; tx_words[2] = 8'h96;
        tx_words[3] = 8'h0F; tx_words[4] = 8'hF0; tx_words[5] = 8'h5A;
        tx_words[6] = 8'hC3; tx_words[7] = 8'h81; tx_words[8] = 8'hFE;
        run_load(3, 10, 0, 0);
        check("stall_edges", res_edges, EXP_EDGES);
        check("stall_chain", chain, model_chain());
        check("stall_done_cycle", res_done_cyc, EXP_STALL_DONE);
        check("stall_clk_low", res_stall_hi, 0);
        check("stall_done_cleared_c1", res_done1, 1'b0);
        ref_chain = chain;

        // bit order: only the first-shifted bit set
        tx_words[0] = 8'h01;
        for (int w = 1; w < NW; w++) tx_words[w] = 8'h00;
        run_load(-1, 0, 0, 0);
        check("order_chain", chain, {1'b1, 64'h0});
        check("order_edges", res_edges, EXP_EDGES);

        // same words as the stalled run, without a stall
        tx_words[0] = 8'hA5; tx_words[1] = 8'h3C; tx_words[2] = 8'h96;
        tx_words[3] = 8'h0F; tx_words[4] = 8'hF0; tx_words[5] = 8'h5A;
        tx_words[6] = 8'hC3; tx_words[7] = 8'h81; tx_words[8] = 8'hFE;
        run_load(-1, 0, 0, 0);
        check("nostall_chain_matches", chain, ref_chain);
        check("nostall_done_cycle", res_done_cyc, EXP_DONE);

        // reset after 20 edges, then a clean reload
        for (int w = 0; w < NW; w++) tx_words[w] = 8'h00;
        run_load(-1, 0, 20, 0);
        check("rst_edges_before_abort", res_edges, 20);
        for (int w = 0; w < NW; w++) tx_words[w] = 8'(8'h11 * (w + 1));
        run_load(-1, 0, 0, 0);
        check("reload_chain", chain, model_chain());
        check("reload_edges", res_edges, EXP_EDGES);
        check("reload_done_cycle", res_done_cyc, EXP_DONE);

        // start pulsed during SHIFT_HI is ignored
        for (int w = 0; w < NW; w++) tx_words[w] = ~(8'(8'h11 * (w + 1)));
        run_load(-1, 0, 0, 30);
        check("poke_in_shift_hi", res_poke_hi, 1'b1);
        check("poke_edges", res_edges, EXP_EDGES);
        check("poke_done_cycle", res_done_cyc, EXP_DONE);
        check("poke_chain", chain, model_chain());

        // corrupt one chain bit right after the last load shift
        for (int w = 0; w < NW; w++) tx_words[w] = 8'h6B;
        flip_edge = edge_cnt + CL;
        run_load(-1, 0, 0, 0);
        flip_edge = -1;
        check("flip_done", done, 1'b1);
        check("flip_error", error, EXP_FLIP_ERR[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
